alu_rs_sched: RTL and testbench
===============================

Name: alu_rs_sched

Overview:
- Reservation station and issue scheduler for the integer ALU in the out-of-order core.
- Accepts calc-class instructions from dispatch (LUI, AUIPC, R-type and I-type arithmetic/logic/shift).
- Holds each instruction until both operands are known, snooping the CDB to capture operands as they are produced.
- Issues at most one ready instruction per cycle to the ALU.

Parameters:
RS_SIZE, 8, number of entries (power of two)
TYPE_W, 6, instruction-type code width (matches the core's type encoding)
ROB_W, 4, ROB tag width

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low freezes the block
clear_in  in  1  pipeline flush (mispredict)
disp_valid  in  1  dispatch request
disp_type  in  TYPE_W  instruction type
disp_vj  in  32  operand j value (valid when disp_qj_busy=0)
disp_qj_busy  in  1  operand j still pending
disp_qj  in  ROB_W  producer tag for j
disp_vk  in  32  operand k value
disp_qk_busy  in  1  operand k pending (0 for immediate forms)
disp_qk  in  ROB_W  producer tag for k
disp_imm  in  32  immediate
disp_pc  in  32  instruction PC
disp_rob  in  ROB_W  destination ROB tag
rs_full  out  1  no free entry
cdb_valid  in  1  result broadcast valid
cdb_rob  in  ROB_W  broadcast tag
cdb_value  in  32  broadcast value
alu_valid  out  1  issue strobe to ALU
alu_type  out  TYPE_W  issued type
alu_v1  out  32  operand j
alu_v2  out  32  operand k
alu_imm  out  32  immediate
alu_pc  out  32  PC
alu_rob  out  ROB_W  destination tag

Behaviour:
- Priority per edge: rst_in > clear_in > rdy_in=0 (hold all state, outputs included) > normal operation.
- Reset and clear: all entries invalid, count=0, rs_full=0, alu_valid=0. All other outputs reset to 0.
- Per-entry state: busy, type, vj, qj_busy, qj, vk, qk_busy, qk, imm, pc, rob.
- Ready condition: busy & !qj_busy & !qk_busy.
- rs_full:
  - Registered.
  - Equals 1 exactly when the entry count after the current edge is RS_SIZE.
- Dispatch:
  - Accepted when disp_valid & !rs_full.
  - Written into the lowest-index free entry.
  - disp_valid while rs_full=1 is ignored; the dispatcher must not assert it.
- Dispatch/CDB bypass:
  - If cdb_valid and cdb_rob equals a busy disp_qj (or disp_qk) in the same cycle, the entry stores cdb_value and that operand is not busy.
- Wakeup:
  - On each edge with cdb_valid, every busy entry whose pending qj/qk equals cdb_rob captures cdb_value into vj/vk and clears the corresponding busy bit.
- Selection:
  - Combinational over registered entry state.
  - Picks the lowest-index ready entry.
  - A newly written or newly woken entry is therefore first selectable in the cycle after its write edge.
- Issue:
  - At the edge, the selected entry's fields are registered onto the alu_* outputs, alu_valid=1, and the entry is freed.
  - alu_valid=0 on any edge with no ready entry. It is a one-cycle strobe per instruction.
- Latency:
  - Dispatch with both operands ready at edge E gives alu_valid=1 after edge E+1.
  - Same for a CDB wakeup at edge E.
- Simultaneous dispatch and issue on one edge: both happen. The count is unchanged. rs_full reflects the result; a freed slot becomes usable the next cycle.
- The count never exceeds RS_SIZE and never underflows.
- No type filtering is performed; non-calc types are the dispatcher's responsibility.

Test Plan:
1. Reset, then dispatch ADDI (qj_busy=0, vj=5, imm=7, qk_busy=0, rob=3) at edge 1 -> alu_valid=1 after edge 2, alu_v1=5, alu_imm=7, alu_rob=3; alu_valid=0 after edge 3.
2. Dispatch ADD with qj_busy=1, qj=6, then CDB broadcasts rob=6, value=0x10 two cycles later -> no issue before the wakeup; alu_valid one cycle after the CDB edge with alu_v1=0x10.
3. Dispatch with disp_qj=2 while cdb_valid, cdb_rob=2, value=9 in the same cycle -> the entry is ready immediately; issues the next cycle with alu_v1=9.
4. Fill 8 entries, all waiting on tag 1 -> rs_full=1; a 9th disp_valid is ignored. Broadcast tag 1 -> eight consecutive alu_valid pulses in entry-index order; rs_full drops after the first issue edge.
5. 4 entries pending, assert clear_in together with disp_valid -> next cycle count=0, rs_full=0, alu_valid=0; the dispatched instruction is discarded.
6. With a ready entry present, hold rdy_in=0 for 3 cycles -> no issue, all outputs frozen; issue occurs one edge after rdy_in returns high.

Source files
------------

// File: rtl/alu_rs_sched.sv
// Reservation station for the integer ALU: holds calc-class instructions until both
// operands are known (snooping the CDB) and issues the lowest-index ready entry each cycle.
module alu_rs_sched #(
    parameter int RS_SIZE = 8,
    parameter int TYPE_W  = 6,
    parameter int ROB_W   = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              disp_valid,
    input  logic [TYPE_W-1:0] disp_type,
    input  logic [31:0]       disp_vj,
    input  logic              disp_qj_busy,
    input  logic [ROB_W-1:0]  disp_qj,
    input  logic [31:0]       disp_vk,
    input  logic              disp_qk_busy,
    input  logic [ROB_W-1:0]  disp_qk,
    input  logic [31:0]       disp_imm,
    input  logic [31:0]       disp_pc,
    input  logic [ROB_W-1:0]  disp_rob,
    output logic              rs_full,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_rob,
    input  logic [31:0]       cdb_value,
    output logic              alu_valid,
    output logic [TYPE_W-1:0] alu_type,
    output logic [31:0]       alu_v1,
    output logic [31:0]       alu_v2,
    output logic [31:0]       alu_imm,
    output logic [31:0]       alu_pc,
    output logic [ROB_W-1:0]  alu_rob
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    logic [RS_SIZE-1:0] busy_reg;
    logic [RS_SIZE-1:0] qj_busy_reg;
    logic [RS_SIZE-1:0] qk_busy_reg;
    logic [TYPE_W-1:0]  type_reg [RS_SIZE];
    logic [31:0]        vj_reg   [RS_SIZE];
    logic [31:0]        vk_reg   [RS_SIZE];
    logic [ROB_W-1:0]   qj_reg   [RS_SIZE];
    logic [ROB_W-1:0]   qk_reg   [RS_SIZE];
    logic [31:0]        imm_reg  [RS_SIZE];
    logic [31:0]        pc_reg   [RS_SIZE];
    logic [ROB_W-1:0]   rob_reg  [RS_SIZE];
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               rs_full_reg;

    logic               alu_valid_reg;
    logic [TYPE_W-1:0]  alu_type_reg;
    logic [31:0]        alu_v1_reg;
    logic [31:0]        alu_v2_reg;
    logic [31:0]        alu_imm_reg;
    logic [31:0]        alu_pc_reg;
    logic [ROB_W-1:0]   alu_rob_reg;

    logic [RS_SIZE-1:0] ready;
    logic [RS_SIZE-1:0] wake_j;
    logic [RS_SIZE-1:0] wake_k;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               free_valid;
    logic [IDX_W-1:0]   free_idx;
    logic               accept;
    logic               byp_j;
    logic               byp_k;

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            assign ready[gi]  = busy_reg[gi] & ~qj_busy_reg[gi] & ~qk_busy_reg[gi];
            assign wake_j[gi] = cdb_valid & busy_reg[gi] & qj_busy_reg[gi] & (qj_reg[gi] == cdb_rob);
            assign wake_k[gi] = cdb_valid & busy_reg[gi] & qk_busy_reg[gi] & (qk_reg[gi] == cdb_rob);
        end
    endgenerate

    // Scan downwards so the last hit is the lowest index.
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy_reg[i]) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign accept     = disp_valid & ~rs_full_reg & free_valid;
    assign byp_j      = disp_qj_busy & cdb_valid & (cdb_rob == disp_qj);
    assign byp_k      = disp_qk_busy & cdb_valid & (cdb_rob == disp_qk);
    assign count_next = count_reg + CNT_W'(accept) - CNT_W'(sel_valid);

    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            busy_reg      <= '0;
            count_reg     <= '0;
            rs_full_reg   <= 1'b0;
            alu_valid_reg <= 1'b0;
            alu_type_reg  <= '0;
            alu_v1_reg    <= '0;
            alu_v2_reg    <= '0;
            alu_imm_reg   <= '0;
            alu_pc_reg    <= '0;
            alu_rob_reg   <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wake_j[i]) begin
                    vj_reg[i]      <= cdb_value;
                    qj_busy_reg[i] <= 1'b0;
                end
                if (wake_k[i]) begin
                    vk_reg[i]      <= cdb_value;
                    qk_busy_reg[i] <= 1'b0;
                end
            end
            alu_valid_reg <= sel_valid;
            if (sel_valid) begin
                busy_reg[sel_idx] <= 1'b0;
                alu_type_reg      <= type_reg[sel_idx];
                alu_v1_reg        <= vj_reg[sel_idx];
                alu_v2_reg        <= vk_reg[sel_idx];
                alu_imm_reg       <= imm_reg[sel_idx];
                alu_pc_reg        <= pc_reg[sel_idx];
                alu_rob_reg       <= rob_reg[sel_idx];
            end
            // The free slot is never the issuing one, so a freed slot is reused only next cycle.
            if (accept) begin
                busy_reg[free_idx]    <= 1'b1;
                type_reg[free_idx]    <= disp_type;
                vj_reg[free_idx]      <= byp_j ? cdb_value : disp_vj;
                qj_busy_reg[free_idx] <= disp_qj_busy & ~byp_j;
                qj_reg[free_idx]      <= disp_qj;
                vk_reg[free_idx]      <= byp_k ? cdb_value : disp_vk;
                qk_busy_reg[free_idx] <= disp_qk_busy & ~byp_k;
                qk_reg[free_idx]      <= disp_qk;
                imm_reg[free_idx]     <= disp_imm;
                pc_reg[free_idx]      <= disp_pc;
                rob_reg[free_idx]     <= disp_rob;
            end
            count_reg   <= count_next;
            rs_full_reg <= (count_next == CNT_W'(RS_SIZE));
        end
    end

    assign rs_full   = rs_full_reg;
    assign alu_valid = alu_valid_reg;
    assign alu_type  = alu_type_reg;
    assign alu_v1    = alu_v1_reg;
    assign alu_v2    = alu_v2_reg;
    assign alu_imm   = alu_imm_reg;
    assign alu_pc    = alu_pc_reg;
    assign alu_rob   = alu_rob_reg;
endmodule

// File: tb/tb_alu_rs_sched.sv
// Scoreboard bench for alu_rs_sched: a slot-level reference model predicts each issue,
// and an independent monitor compares every cycle's ALU outputs against the queue.
module tb_alu_rs_sched;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        disp_valid, disp_qj_busy, disp_qk_busy;
    logic [5:0]  disp_type;
    logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
    logic [3:0]  disp_qj, disp_qk, disp_rob;
    logic        rs_full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_value;
    logic        alu_valid;
    logic [5:0]  alu_type;
    logic [31:0] alu_v1, alu_v2, alu_imm, alu_pc;
    logic [3:0]  alu_rob;

    alu_rs_sched #(.RS_SIZE(8), .TYPE_W(6), .ROB_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_vj(disp_vj),
        .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj), .disp_vk(disp_vk),
        .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk), .disp_imm(disp_imm),
        .disp_pc(disp_pc), .disp_rob(disp_rob), .rs_full(rs_full),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
        .alu_valid(alu_valid), .alu_type(alu_type), .alu_v1(alu_v1), .alu_v2(alu_v2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob(alu_rob)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          busy;
        logic [5:0]  typ;
        logic [31:0] vj, vk, imm, pc;
        bit          qjb, qkb;
        logic [3:0]  qj, qk, rob;
    } slot_t;

    typedef struct {
        int          cyc;
        logic [5:0]  typ;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  rob;
    } exp_t;

    slot_t m [8];
    int    m_count = 0;
    bit    m_full = 0;
    exp_t  sbq [$];
    int    cyc = 0;
    bit    frozen_edge = 0;
    bit    mon_en = 0;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic idle();
        disp_valid = 0; disp_type = 0; disp_vj = 0; disp_qj_busy = 0; disp_qj = 0;
        disp_vk = 0; disp_qk_busy = 0; disp_qk = 0; disp_imm = 0; disp_pc = 0; disp_rob = 0;
        cdb_valid = 0; cdb_rob = 0; cdb_value = 0;
        clear_in = 0; rdy_in = 1; rst_in = 0;
    endtask

    task automatic set_disp(input logic [5:0] t, input logic [31:0] vj, input bit qjb,
                            input logic [3:0] qj, input logic [31:0] vk, input bit qkb,
                            input logic [3:0] qk, input logic [31:0] imm,
                            input logic [31:0] pc, input logic [3:0] rob);
        disp_valid = 1; disp_type = t; disp_vj = vj; disp_qj_busy = qjb; disp_qj = qj;
        disp_vk = vk; disp_qk_busy = qkb; disp_qk = qk; disp_imm = imm; disp_pc = pc;
        disp_rob = rob;
    endtask

    // Apply the current inputs to the model, clock one edge, then check rs_full.
    task automatic tick();
        int    iss;
        int    fr;
        bit    frz;
        slot_t s;
        exp_t  e;
        frz = 0;
        if (rst_in || clear_in) begin
            for (int i = 0; i < 8; i++) m[i].busy = 0;
            m_count = 0;
            m_full  = 0;
        end else if (!rdy_in) begin
            frz = 1;
        end else begin
            iss = -1;
            fr  = -1;
            for (int i = 0; i < 8; i++) begin
                if (iss < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) iss = i;
                if (fr < 0 && !m[i].busy) fr = i;
            end
            if (iss >= 0) begin
                e.cyc = cyc + 1; e.typ = m[iss].typ; e.v1 = m[iss].vj; e.v2 = m[iss].vk;
                e.imm = m[iss].imm; e.pc = m[iss].pc; e.rob = m[iss].rob;
                sbq.push_back(e);
                m[iss].busy = 0;
                m_count--;
            end
            if (cdb_valid) begin
                for (int i = 0; i < 8; i++) begin
                    if (m[i].busy && m[i].qjb && m[i].qj == cdb_rob) begin
                        m[i].vj = cdb_value; m[i].qjb = 0;
                    end
                    if (m[i].busy && m[i].qkb && m[i].qk == cdb_rob) begin
                        m[i].vk = cdb_value; m[i].qkb = 0;
                    end
                end
            end
            if (disp_valid && !m_full && fr >= 0) begin
                s.busy = 1; s.typ = disp_type; s.imm = disp_imm; s.pc = disp_pc; s.rob = disp_rob;
                s.qj = disp_qj; s.qk = disp_qk;
                s.qjb = disp_qj_busy; s.vj = disp_vj;
                s.qkb = disp_qk_busy; s.vk = disp_vk;
                if (s.qjb && cdb_valid && cdb_rob == s.qj) begin s.qjb = 0; s.vj = cdb_value; end
                if (s.qkb && cdb_valid && cdb_rob == s.qk) begin s.qkb = 0; s.vk = cdb_value; end
                m[fr] = s;
                m_count++;
            end
            m_full = (m_count == 8);
        end
        @(posedge clk_in);
        #1;
        cyc++;
        frozen_edge = frz;
        n_vec++;
        if (rs_full !== m_full) begin
            n_err++;
            $display("FAIL rs_full cyc=%0d got=%b want=%b", cyc, rs_full, m_full);
        end
    endtask

    // Monitor: compares ALU outputs each cycle, independent of the stimulus process.
    logic       prev_valid = 0;
    logic [3:0] prev_rob = 0;
    initial begin
        bit   exp_now;
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (mon_en) begin
                n_vec++;
                if (frozen_edge) begin
                    if (alu_valid !== prev_valid || alu_rob !== prev_rob) begin
                        n_err++;
                        $display("FAIL frozen_hold cyc=%0d got valid=%b rob=%0d want valid=%b rob=%0d",
                                 cyc, alu_valid, alu_rob, prev_valid, prev_rob);
                    end
                end else begin
                    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                        e = sbq.pop_front();
                        n_err++;
                        $display("FAIL late_issue rob=%0d got=none want_cyc=%0d", e.rob, e.cyc);
                    end
                    exp_now = (sbq.size() > 0 && sbq[0].cyc == cyc);
                    if (alu_valid !== exp_now) begin
                        n_err++;
                        $display("FAIL alu_valid cyc=%0d got=%b want=%b", cyc, alu_valid, exp_now);
                    end
                    if (exp_now) begin
                        e = sbq.pop_front();
                        if (alu_valid === 1'b1) begin
                            n_vec++;
                            $display("issue cyc=%0d rob=%0d type=%0h v1=%h v2=%h imm=%h pc=%h",
                                     cyc, alu_rob, alu_type, alu_v1, alu_v2, alu_imm, alu_pc);
                            if (alu_type !== e.typ || alu_v1 !== e.v1 || alu_v2 !== e.v2 ||
                                alu_imm !== e.imm || alu_pc !== e.pc || alu_rob !== e.rob) begin
                                n_err++;
                                $display("FAIL issue_fields cyc=%0d got rob=%0d t=%0h v1=%h v2=%h imm=%h pc=%h want rob=%0d t=%0h v1=%h v2=%h imm=%h pc=%h",
                                         cyc, alu_rob, alu_type, alu_v1, alu_v2, alu_imm, alu_pc,
                                         e.rob, e.typ, e.v1, e.v2, e.imm, e.pc);
                            end
                        end
                    end
                end
            end
            prev_valid = alu_valid;
            prev_rob   = alu_rob;
        end
    end

    initial begin
        idle();
        rst_in = 1;
        tick();
        mon_en = 1;
        tick();
        rst_in = 0;
        n_vec++;
        if (alu_valid !== 0 || alu_v1 !== 0 || alu_imm !== 0 || alu_rob !== 0 || alu_type !== 0) begin
            n_err++;
            $display("FAIL reset_outputs got valid=%b v1=%h imm=%h rob=%0d want all zero",
                     alu_valid, alu_v1, alu_imm, alu_rob);
        end

        // Ready-at-dispatch ADDI.
        set_disp(6'h13, 32'd5, 0, 0, 32'd0, 0, 0, 32'd7, 32'h100, 4'd3);
        tick(); idle();
        repeat (3) tick();

        // Operand j waits for tag 6, woken two cycles later.
        set_disp(6'h33, 32'd0, 1, 4'd6, 32'd2, 0, 0, 32'd0, 32'h104, 4'd4);
        tick(); idle();
        repeat (2) tick();
        cdb_valid = 1; cdb_rob = 4'd6; cdb_value = 32'h10;
        tick(); idle();
        repeat (3) tick();

        // Same-cycle CDB bypass into dispatch.
        set_disp(6'h33, 32'd0, 1, 4'd2, 32'd1, 0, 0, 32'd0, 32'h108, 4'd5);
        cdb_valid = 1; cdb_rob = 4'd2; cdb_value = 32'd9;
        tick(); idle();
        repeat (3) tick();

        // Fill all eight, ninth ignored, then one broadcast drains them in order.
        for (int i = 0; i < 9; i++) begin
            set_disp(6'h33, 32'd0, 1, 4'd1, 32'(i), 0, 0, 32'(i), 32'h200 + 32'(4 * i), 4'(i + 7));
            tick();
        end
        idle();
        tick();
        cdb_valid = 1; cdb_rob = 4'd1; cdb_value = 32'hABCD;
        tick(); idle();
        repeat (10) tick();

        // Clear with four pending and a simultaneous dispatch.
        for (int i = 0; i < 4; i++) begin
            set_disp(6'h13, 32'd0, 1, 4'd5, 32'd0, 0, 0, 32'(i), 32'h300, 4'(i));
            tick();
        end
        set_disp(6'h13, 32'd1, 0, 0, 32'd0, 0, 0, 32'd1, 32'h310, 4'd9);
        clear_in = 1;
        tick(); idle();
        cdb_valid = 1; cdb_rob = 4'd5; cdb_value = 32'd1;
        tick(); idle();
        repeat (3) tick();

        // Freeze with a ready entry present.
        set_disp(6'h13, 32'd11, 0, 0, 32'd0, 0, 0, 32'd12, 32'h400, 4'd14);
        tick(); idle();
        rdy_in = 0;
        repeat (3) tick();
        rdy_in = 1;
        repeat (3) tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(0, 1) == 1)
                set_disp(6'($urandom), $urandom, bit'($urandom_range(0, 1)), 4'($urandom),
                         $urandom, bit'($urandom_range(0, 2) == 0), 4'($urandom),
                         $urandom, $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                cdb_valid = 1; cdb_rob = 4'($urandom); cdb_value = $urandom;
            end
            rdy_in   = ($urandom_range(0, 9) != 0);
            clear_in = ($urandom_range(0, 199) == 0);
            tick();
        end

        // Drain: broadcast every tag so nothing stays pending.
        idle();
        for (int n = 0; n < 48; n++) begin
            cdb_valid = 1; cdb_rob = 4'(n); cdb_value = 32'(n * 3);
            tick();
        end
        idle();
        repeat (12) tick();

        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d leftover want=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
